register_fetch_sequencer: RTL and testbench

// Drives the single-ported register_file for one instruction: two operand reads (SRC0, SRC1),
// a wait for the execute result, then a write-back to DST. Sits between the microcode/decode

---
 rtl/register_fetch_sequencer_if.sv | 40 ++++
 rtl/register_fetch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_register_fetch_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/register_fetch_sequencer_if.sv
// Handshake and register-file bus between decode, execute, register_file and the
// register fetch sequencer. The master modport is the sequencer side.
interface register_fetch_sequencer_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] src0;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] dst;
    logic              no_wb;
    logic              busy;
    logic [1:0]        reg_sel;
    logic [ADDR_W-1:0] reg_src0;
    logic [ADDR_W-1:0] reg_src1;
    logic [ADDR_W-1:0] reg_src2;
    logic              rf_n_oe;
    logic              rf_n_we;
    logic [WIDTH-1:0]  rf_out_data;
    logic [WIDTH-1:0]  rf_in_data;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              op_valid;
    logic [WIDTH-1:0]  res_data;
    logic              res_valid;
    logic              done;
    logic              err;

    modport master (
        input  start, src0, src1, dst, no_wb, rf_out_data, res_data, res_valid,
        output busy, reg_sel, reg_src0, reg_src1, reg_src2, rf_n_oe, rf_n_we,
               rf_in_data, op_a, op_b, op_valid, done, err
    );

    modport slave (
        output start, src0, src1, dst, no_wb, rf_out_data, res_data, res_valid,
        input  busy, reg_sel, reg_src0, reg_src1, reg_src2, rf_n_oe, rf_n_we,
               rf_in_data, op_a, op_b, op_valid, done, err
    );
endinterface

// File: rtl/register_fetch_sequencer.sv
// Register fetch sequencer: reads two operands from a single-ported register file,
// waits for the execute result, then writes it back. Control outputs are decoded
// from the state register so read and write enables can never overlap.
//
// state  | meaning
// IDLE   | waiting for START, BUSY low
// RD0    | reading SRC0 (REG_SEL=00, N_OE low), OP_A captured at exit
// RD1    | reading SRC1 (REG_SEL=01, N_OE low), OP_B captured at exit
// EXEC   | operands valid, waiting for RES_VALID or timeout
// WSET   | DST address settling (REG_SEL=10), enables high
// WR     | single write pulse (N_WE low)
// DONE   | one-cycle completion pulse, ERR if the wait timed out
module register_fetch_sequencer #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter bit ZERO_R0 = 1'b1,
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    register_fetch_sequencer_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_EXEC = 3'd3,
        S_WSET = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src0_q, src0_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic              no_wb_q, no_wb_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  wb_data_q, wb_data_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              abort_q, abort_d;

    logic timeout_hit;
    logic skip_write;

    assign timeout_hit = (TIMEOUT > 0) && (tmo_cnt_q == TMO_LAST);
    assign skip_write  = no_wb_q || (ZERO_R0 && (dst_q == '0));

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            src0_q    <= '0;
            src1_q    <= '0;
            dst_q     <= '0;
            no_wb_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wb_data_q <= '0;
            tmo_cnt_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            dst_q     <= dst_d;
            no_wb_q   <= no_wb_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            wb_data_q <= wb_data_d;
            tmo_cnt_q <= tmo_cnt_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RD0;
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_EXEC;
            S_EXEC: begin
                if (bus.res_valid)  state_d = skip_write ? S_DONE : S_WSET;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_WSET:  state_d = S_WR;
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Index latch, operand/result capture and the EXEC wait counter
    always_comb begin
        src0_d    = src0_q;
        src1_d    = src1_q;
        dst_d     = dst_q;
        no_wb_d   = no_wb_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        wb_data_d = wb_data_q;
        tmo_cnt_d = tmo_cnt_q;
        abort_d   = abort_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    src0_d  = bus.src0;
                    src1_d  = bus.src1;
                    dst_d   = bus.dst;
                    no_wb_d = bus.no_wb;
                end
            end
            S_RD0: op_a_d = (ZERO_R0 && (src0_q == '0)) ? '0 : bus.rf_out_data;
            S_RD1: op_b_d = (ZERO_R0 && (src1_q == '0)) ? '0 : bus.rf_out_data;
            S_EXEC: begin
                if (tmo_cnt_q != CNT_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (bus.res_valid)        wb_data_d = bus.res_data;
                else if (timeout_hit)     abort_d   = 1'b1;
            end
            S_DONE: begin
                tmo_cnt_d = '0;
                abort_d   = 1'b0;
            end
            default: ;
        endcase
    end

    // Moore control outputs decoded from the state register
    always_comb begin
        bus.busy     = (state_q != S_IDLE);
        bus.reg_sel  = 2'b00;
        bus.rf_n_oe  = 1'b1;
        bus.rf_n_we  = 1'b1;
        bus.op_valid = 1'b0;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        case (state_q)
            S_RD0:  bus.rf_n_oe = 1'b0;
            S_RD1: begin
                bus.reg_sel = 2'b01;
                bus.rf_n_oe = 1'b0;
            end
            S_EXEC: begin
                bus.reg_sel  = 2'b01;
                bus.op_valid = 1'b1;
            end
            S_WSET: bus.reg_sel = 2'b10;
            S_WR: begin
                bus.reg_sel = 2'b10;
                bus.rf_n_we = 1'b0;
            end
            S_DONE: begin
                bus.reg_sel = 2'b10;
                bus.done    = 1'b1;
                bus.err     = abort_q;
            end
            default: ;
        endcase
    end

    assign bus.reg_src0   = src0_q;
    assign bus.reg_src1   = src1_q;
    assign bus.reg_src2   = dst_q;
    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.rf_in_data = wb_data_q;

endmodule

// File: tb/tb_register_fetch_sequencer.sv
// Bench for register_fetch_sequencer: a behavioural register file plus a reference
// model of the instruction sequence (operand values, write-back, completion timing).
module tb_register_fetch_sequencer;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_fetch_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    register_fetch_sequencer #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_R0(1'b1), .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;

    logic [WIDTH-1:0] rf_mem    [32];
    logic [WIDTH-1:0] model_mem [32];
    logic [ADDR_W-1:0] rf_addr;
    logic [WIDTH-1:0]  rf_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register file: combinational read of the selected index, write on N_WE low
    always_comb begin
        rf_addr = bus.reg_src2;
        if (bus.reg_sel == 2'b00) rf_addr = bus.reg_src0;
        else if (bus.reg_sel == 2'b01) rf_addr = bus.reg_src1;
        rf_rdata = bus.rf_n_oe ? 32'hDEAD_BEEF : rf_mem[rf_addr];
    end
    assign bus.rf_out_data = rf_rdata;

    always @(posedge clk) begin
        if (!bus.rf_n_we) begin
            rf_mem[bus.reg_src2] = bus.rf_in_data;
            wr_cnt++;
        end
    end

    // Enable-overlap and REG_SEL invariants on every cycle
    always @(negedge clk) begin
        check("no_oe_we_overlap", {31'd0, (!bus.rf_n_oe && !bus.rf_n_we)}, 32'd0);
        check("reg_sel_not_11", {31'd0, (bus.reg_sel == 2'b11)}, 32'd0);
    end

    function automatic logic [31:0] model_read(input int idx);
        return (idx == 0) ? 32'd0 : model_mem[idx];
    endfunction

    // One full instruction; inputs change #1 after edges, outputs sampled there too
    task automatic run_txn(input int s0, input int s1, input int d, input bit nwb,
                           input logic [31:0] res, input int dly);
        logic [31:0] exp_a, exp_b;
        bit exp_wr;
        int wr0;
        exp_a  = model_read(s0);
        exp_b  = model_read(s1);
        exp_wr = !nwb && (d != 0);
        wr0    = wr_cnt;
        bus.src0  = ADDR_W'(s0);
        bus.src1  = ADDR_W'(s1);
        bus.dst   = ADDR_W'(d);
        bus.no_wb = nwb;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.src0  = ADDR_W'($urandom);
        bus.src1  = ADDR_W'($urandom);
        bus.dst   = ADDR_W'($urandom);
        bus.no_wb = $urandom_range(0, 1);
        check("rd0_busy", {31'd0, bus.busy}, 32'd1);
        check("rd0_sel_oe", {29'd0, bus.reg_sel, bus.rf_n_oe}, 32'b000);
        @(posedge clk); #1;
        check("rd1_sel_oe_valid", {28'd0, bus.reg_sel, bus.rf_n_oe, bus.op_valid}, 32'b0100);
        @(posedge clk); #1;
        check("exec_valid_oe", {29'd0, bus.op_valid, bus.rf_n_oe, bus.rf_n_we}, 32'b111);
        check("exec_op_a", bus.op_a, exp_a);
        check("exec_op_b", bus.op_b, exp_b);
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            check("exec_wait", {30'd0, bus.op_valid, bus.done}, 32'b10);
        end
        bus.res_data  = res;
        bus.res_valid = 1'b1;
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        bus.res_data  = $urandom;
        if (exp_wr) begin
            check("wset_sel_we_done", {28'd0, bus.reg_sel, bus.rf_n_we, bus.done}, 32'b1010);
            @(posedge clk); #1;
            check("wr_sel_we_oe", {28'd0, bus.reg_sel, bus.rf_n_we, bus.rf_n_oe}, 32'b1001);
            check("wr_data", bus.rf_in_data, res);
            @(posedge clk); #1;
        end
        check("done_err", {28'd0, bus.done, bus.err, bus.rf_n_we, bus.rf_n_oe}, 32'b1011);
        check("done_sel", {30'd0, bus.reg_sel}, 32'b10);
        check("write_count", wr_cnt - wr0, exp_wr ? 32'd1 : 32'd0);
        if (exp_wr) model_mem[d] = res;
        check("rf_dst_value", rf_mem[d], model_mem[d]);
        @(posedge clk); #1;
        check("idle_after_done", {30'd0, bus.busy, bus.done}, 32'b00);
    endtask

    initial begin
        logic [31:0] r;
        int wr_before;
        bus.start = 1'b0; bus.src0 = '0; bus.src1 = '0; bus.dst = '0; bus.no_wb = 1'b0;
        bus.res_data = '0; bus.res_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            r = $urandom;
            rf_mem[i] = r;
            model_mem[i] = r;
        end
        rf_mem[3] = 32'h11; model_mem[3] = 32'h11;
        rf_mem[4] = 32'h22; model_mem[4] = 32'h22;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_done_err_valid", {28'd0, bus.busy, bus.done, bus.err, bus.op_valid}, 32'd0);
        check("rst_sel_oe_we", {28'd0, bus.reg_sel, bus.rf_n_oe, bus.rf_n_we}, 32'b0011);
        check("rst_ops", bus.op_a | bus.op_b | bus.rf_in_data, 32'd0);
        check("rst_idx", {17'd0, bus.reg_src0, bus.reg_src1, bus.reg_src2}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic read/execute/write-back
        run_txn(3, 4, 7, 1'b0, 32'h33, 0);
        // r0 reads as zero and write to r0 is suppressed
        rf_mem[0] = 32'hFFFF_FFFF; model_mem[0] = 32'hFFFF_FFFF;
        run_txn(0, 5, 0, 1'b0, 32'hABCD_0123, 1);
        check("r0_untouched", rf_mem[0], 32'hFFFF_FFFF);
        // No write-back
        run_txn(6, 6, 9, 1'b1, 32'h5555_AAAA, 2);
        // Same register for all three
        run_txn(12, 12, 12, 1'b0, 32'h0BAD_F00D, 3);

        // Timeout: four EXEC cycles without a result
        wr_before = wr_cnt;
        bus.src0 = 5'd1; bus.src1 = 5'd2; bus.dst = 5'd8; bus.no_wb = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("tmo_exec_entry", {31'd0, bus.op_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("tmo_still_exec", {30'd0, bus.op_valid, bus.done}, 32'b10);
        end
        @(posedge clk); #1;
        check("tmo_done_err", {30'd0, bus.done, bus.err}, 32'b11);
        @(posedge clk); #1;
        check("tmo_idle", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
        check("tmo_no_write", wr_cnt - wr_before, 32'd0);
        check("tmo_dst_kept", rf_mem[8], model_mem[8]);

        // START while busy is ignored; reset during WSET aborts with no write
        wr_before = wr_cnt;
        bus.src0 = 5'd3; bus.src1 = 5'd4; bus.dst = 5'd10; bus.no_wb = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.src0 = 5'd4; bus.src1 = 5'd3; bus.dst = 5'd11;
        repeat (2) @(posedge clk);
        #1;
        check("busy_start_op_a", bus.op_a, model_read(3));
        check("busy_start_op_b", bus.op_b, model_read(4));
        check("busy_start_dst", {27'd0, bus.reg_src2}, 32'd10);
        bus.start = 1'b0;
        bus.res_data = 32'h7777_7777; bus.res_valid = 1'b1;
        @(posedge clk); #1;
        bus.res_valid = 1'b0;
        check("abort_in_wset", {30'd0, bus.reg_sel}, 32'b10);
        rst = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        check("abort_ctrl", {26'd0, bus.busy, bus.reg_sel, bus.rf_n_oe, bus.rf_n_we, bus.done}, 32'b000110);
        check("abort_data", bus.op_a | bus.op_b | bus.rf_in_data, 32'd0);
        @(posedge clk); #1;
        check("abort_rst_wins", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        check("abort_no_write", wr_cnt - wr_before, 32'd0);
        check("abort_dst_kept", rf_mem[10], model_mem[10]);

        // Randomized back-to-back instructions
        for (int n = 0; n < 40; n++) begin
            run_txn($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
        end
        for (int i = 0; i < 32; i++) check("final_mem", rf_mem[i], model_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
